// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser followed by a debounce FSM
// that emits a clean level x and a one-cycle rising-edge pulse x_rise.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic x,
  output logic x_rise
);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // A window outside 2..2**CNT_W-1 would make the counter wrap or the FSM degenerate.
  generate
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
      $error("button_debouncer: DEBOUNCE_CYCLES=%0d outside legal range 2..%0d",
             DEBOUNCE_CYCLES, (2 ** CNT_W) - 1);
    end
  endgenerate

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Only the synchronised s2 is ever examined here; x and x_rise are flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_LOW;
      cnt    <= CNT_ZERO;
      x      <= 1'b0;
      x_rise <= 1'b0;
    end else begin
      x_rise <= 1'b0;
      case (state)
        S_LOW: begin
          x <= 1'b0;
          if (s2) begin
            state <= S_RISE_CHK;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= CNT_ZERO;
          end
        end
        S_RISE_CHK: begin
          if (!s2) begin
            state <= S_LOW;
            cnt   <= CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state  <= S_HIGH;
            x      <= 1'b1;
            x_rise <= 1'b1;
            cnt    <= CNT_ZERO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          x <= 1'b1;
          if (!s2) begin
            state <= S_FALL_CHK;
            cnt   <= CNT_ONE;
          end
        end
        S_FALL_CHK: begin
          if (s2) begin
            state <= S_HIGH;
            cnt   <= CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state <= S_LOW;
            x     <= 1'b0;
            cnt   <= CNT_ZERO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= CNT_ZERO;
          x     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random
// bouncing, compared against a run-length reference model.
module tb_button_debouncer;

  localparam int DB = 4;

  logic clock;
  logic reset;
  logic btn;
  logic x;
  logic x_rise;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: btn reaches the decision logic two edges late; x flips
  // once DB consecutive delayed samples disagree with the current x.
  logic m_d1, m_d2;
  int   m_run;
  logic m_x, m_rise;
  int   dut_rises;

  button_debouncer #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .btn    (btn),
    .x      (x),
    .x_rise (x_rise)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = 1'b0;
    m_d2 = 1'b0;
    m_run = 0;
    m_x = 1'b0;
    m_rise = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    logic seen;
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = b;
    m_rise = 1'b0;
    if (seen != m_x) m_run++;
    else m_run = 0;
    if (m_run == DB) begin
      m_rise = ~m_x;
      m_x = seen;
      m_run = 0;
    end
  endtask

  // Drive btn, take one edge, compare 1 ns after it.
  task automatic step(input logic b);
    btn = b;
    @(posedge clock);
    model_edge(b);
    #1;
    if (x_rise === 1'b1) dut_rises++;
    check("x", int'(x), int'(m_x));
    check("x_rise", int'(x_rise), int'(m_rise));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("x_in_reset", int'(x), 0);
    check("x_rise_in_reset", int'(x_rise), 0);
    reset = 1'b0;
  endtask

  initial begin
    int rise_idx;
    int lvl;
    int len;

    // Reset held 22 ns with the button already pressed.
    reset = 1'b1;
    btn = 1'b1;
    model_reset();
    dut_rises = 0;
    for (int i = 0; i < 4; i++) begin
      #4;
      check("reset_x", int'(x), 0);
      check("reset_x_rise", int'(x_rise), 0);
    end
    #6;
    reset = 1'b0;
    rise_idx = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (x === 1'b1 && rise_idx < 0) rise_idx = i;
    end
    check("post_reset_latency_edges", rise_idx, DB + 2);
    check("hold_single_rise", dut_rises, 1);

    // Clean release then clean press with long hold.
    for (int i = 0; i < 10; i++) step(1'b0);
    check("released", int'(x), 0);
    dut_rises = 0;
    rise_idx = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (x === 1'b1 && rise_idx < 0) rise_idx = i;
    end
    check("press_latency_edges", rise_idx, DB + 2);
    check("press_single_rise", dut_rises, 1);

    // Bounce then settle high.
    for (int i = 0; i < 10; i++) step(1'b0);
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    rise_idx = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      if (x === 1'b1 && rise_idx < 0) rise_idx = i;
    end
    check("bounce_latency_edges", rise_idx, DB + 2);

    // Short low glitch while high, then a real release.
    dut_rises = 0;
    step(1'b0); step(1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      check("glitch_hold_x", int'(x), 1);
    end
    rise_idx = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0);
      if (x === 1'b0 && rise_idx < 0) rise_idx = i;
    end
    check("fall_latency_edges", rise_idx, DB + 2);
    check("no_pulse_on_glitch_or_fall", dut_rises, 0);

    // Reset mid-debounce: pending change discarded, full window after release.
    step(1'b1); step(1'b1); step(1'b1);
    pulse_reset();
    rise_idx = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      if (x === 1'b1 && rise_idx < 0) rise_idx = i;
    end
    check("reset_mid_latency_edges", rise_idx, DB + 2);

    // Random bouncing segments with occasional asynchronous reset.
    lvl = 0;
    for (int seg = 0; seg < 400; seg++) begin
      lvl = (($urandom_range(0, 3)) == 0) ? lvl : 1 - lvl;
      len = (($urandom_range(0, 2)) == 0) ? $urandom_range(DB, DB + 6)
                                          : $urandom_range(1, DB);
      for (int k = 0; k < len; k++) step(lvl[0]);
      if ($urandom_range(0, 60) == 0) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
